// File: rtl/cordic_seq_ctrl_pkg.sv
// Shared definitions for the iterative CORDIC sequencer: state encoding,
// arctangent table, default widths and saturation limit helpers.
package cordic_seq_ctrl_pkg;

  localparam int W_DEF     = 8;
  localparam int IW_DEF    = 10;
  localparam int ITERS_DEF = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // atan(2^-i) in binary-angle units (0x40 = 90deg); last slot pads the 3-bit index
  localparam logic [7:0] ATAN_TBL [8] = '{8'd32, 8'd19, 8'd10, 8'd5, 8'd3, 8'd1, 8'd1, 8'd0};

  function automatic int sat_hi(input int w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// Request/result handshake bundle between the angle source, the CORDIC
// sequencer and the downstream sin/cos consumer.
interface cordic_seq_ctrl_if #(
  parameter int W = 8
) ();

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic signed [W-1:0] z_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;
  logic                sat;

  modport master (
    output in_valid, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, sat
  );

  modport slave (
    input  in_valid, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, sat
  );

endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational micro-rotation angle lookup: iteration index -> atan(2^-i).
module cordic_atan_rom
  import cordic_seq_ctrl_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [2:0]          i_idx,
  output logic signed [W-1:0] o_atan
);

  always_comb begin
    o_atan = W'(ATAN_TBL[i_idx]);
  end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Rotation-mode CORDIC sequencer: quadrant pre-correction, ITERS shift-add
// micro-rotations, then saturated result held until the consumer accepts it.
module cordic_seq_ctrl
  import cordic_seq_ctrl_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int IW    = IW_DEF,
  parameter int ITERS = ITERS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  cordic_seq_ctrl_if.slave  io_bus,
  output logic              busy
);

  localparam logic [2:0]          LAST_IT = 3'(ITERS - 1);
  localparam logic signed [IW-1:0] SAT_HI = IW'(sat_hi(W));
  localparam logic signed [IW-1:0] SAT_LO = IW'(sat_lo(W));
  localparam logic signed [W-1:0]  Z_HALF = {1'b1, {(W-1){1'b0}}};

  state_t               r_state;
  logic [2:0]           r_iter;
  logic signed [IW-1:0] r_x;
  logic signed [IW-1:0] r_y;
  logic signed [W-1:0]  r_z;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic signed [W-1:0]  r_x_out;
  logic signed [W-1:0]  r_y_out;
  logic                 r_sat;
  logic                 r_busy;

  logic                 w_flag;
  logic                 w_dpos;
  logic signed [W-1:0]  w_atan;
  logic signed [IW-1:0] w_xsh;
  logic signed [IW-1:0] w_ysh;
  logic signed [IW-1:0] w_x_nxt;
  logic signed [IW-1:0] w_y_nxt;
  logic signed [W-1:0]  w_z_nxt;

  // Quadrant converter: two's-complement negate when flagged, pass otherwise
  function automatic logic signed [IW-1:0] conv(input logic flag,
                                                input logic signed [IW-1:0] v);
    return flag ? -v : v;
  endfunction

  function automatic logic signed [W-1:0] sat_val(input logic signed [IW-1:0] v);
    if (v > SAT_HI)      return W'(SAT_HI);
    else if (v < SAT_LO) return W'(SAT_LO);
    else                 return W'(v);
  endfunction

  function automatic logic clipped(input logic signed [IW-1:0] v);
    return (v > SAT_HI) || (v < SAT_LO);
  endfunction

  cordic_atan_rom #(.W(W)) u_atan (
    .i_idx  (r_iter),
    .o_atan (w_atan)
  );

  assign w_flag  = r_z[W-1] ^ r_z[W-2];
  assign w_dpos  = ~r_z[W-1];
  assign w_xsh   = r_x >>> r_iter;
  assign w_ysh   = r_y >>> r_iter;
  assign w_x_nxt = w_dpos ? (r_x - w_ysh)  : (r_x + w_ysh);
  assign w_y_nxt = w_dpos ? (r_y + w_xsh)  : (r_y - w_xsh);
  assign w_z_nxt = w_dpos ? (r_z - w_atan) : (r_z + w_atan);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_iter      <= 3'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_sat       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.in_valid && r_in_ready) begin
            r_x        <= IW'(io_bus.x_in);
            r_y        <= IW'(io_bus.y_in);
            r_z        <= io_bus.z_in;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_PRE;
          end
        end
        S_PRE: begin
          // Fold |z|>90deg into the right half-plane by rotating 180deg
          r_x     <= conv(w_flag, r_x);
          r_y     <= conv(w_flag, r_y);
          r_z     <= w_flag ? (r_z + Z_HALF) : r_z;
          r_iter  <= 3'd0;
          r_state <= S_ITER;
        end
        S_ITER: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          if (r_iter == LAST_IT) begin
            r_iter      <= 3'd0;
            r_x_out     <= sat_val(w_x_nxt);
            r_y_out     <= sat_val(w_y_nxt);
            r_sat       <= clipped(w_x_nxt) || clipped(w_y_nxt);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_iter <= r_iter + 3'd1;
          end
        end
        S_DONE: begin
          // A same-cycle new request is deliberately left for the next IDLE cycle
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.x_out     = r_x_out;
  assign io_bus.y_out     = r_y_out;
  assign io_bus.sat       = r_sat;
  assign busy             = r_busy;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Bench for cordic_seq_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level CORDIC model.
module tb_cordic_seq_ctrl;

  localparam int W     = 8;
  localparam int IW    = 10;
  localparam int ITERS = 7;
  localparam int ATAN_T [7] = '{32, 19, 10, 5, 3, 1, 1};

  typedef struct packed {
    int   x;
    int   y;
    logic s;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_chk = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  cordic_seq_ctrl_if #(.W(W)) bus ();

  cordic_seq_ctrl #(.W(W), .IW(IW), .ITERS(ITERS)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  function automatic int clip8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Whole-transaction CORDIC result from the arithmetic rules alone
  function automatic res_t model(input int xi, input int yi, input int zi);
    int x, y, zb, nx, ny, flag;
    res_t r;
    x = xi; y = yi; zb = zi & 255;
    flag = ((zb >> 7) ^ (zb >> 6)) & 1;
    if (flag != 0) begin
      x = -x; y = -y; zb = (zb + 128) & 255;
    end
    for (int i = 0; i < ITERS; i++) begin
      if (zb < 128) begin
        nx = x - (y >>> i); ny = y + (x >>> i); zb = (zb - ATAN_T[i]) & 255;
      end else begin
        nx = x + (y >>> i); ny = y - (x >>> i); zb = (zb + ATAN_T[i]) & 255;
      end
      x = nx; y = ny;
    end
    r.s = (x > 127) || (x < -128) || (y > 127) || (y < -128);
    r.x = clip8(x);
    r.y = clip8(y);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    n_chk++;
    if (act < exp - tol || act > exp + tol) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d+/-%0d t=%0t", name, act, exp, tol, $time);
    end
  endtask

  // Cycle-level expectation: -1 idle, 0..ITERS counting cycles since accept, ITERS+1 result held
  int   m_cnt;
  res_t m_pend;
  res_t m_out;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= -1;
      m_out <= '0;
    end else if (m_cnt == -1) begin
      if (bus.in_valid) begin
        m_pend <= model(int'($signed(bus.x_in)), int'($signed(bus.y_in)), int'($signed(bus.z_in)));
        m_cnt  <= 0;
      end
    end else if (m_cnt < ITERS + 1) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == ITERS) m_out <= m_pend;
    end else if (bus.out_ready) begin
      m_cnt <= -1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  int'(bus.in_ready),  int'(m_cnt == -1));
      chk("busy",      int'(busy),          int'(m_cnt != -1));
      chk("out_valid", int'(bus.out_valid), int'(m_cnt == ITERS + 1));
      chk("x_out",     int'($signed(bus.x_out)), m_out.x);
      chk("y_out",     int'($signed(bus.y_out)), m_out.y);
      chk("sat",       int'(bus.sat),       int'(m_out.s));
    end
  end

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'h40;
      default: return 8'($urandom);
    endcase
  endfunction

  // Present a request and return at the negedge just after the accepting edge
  task automatic start(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    int n;
    n = 0;
    bus.x_in = x; bus.y_in = y; bus.z_in = z; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", int'(n >= 50), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Latency counted in cycles with the handshake cycle as cycle 0
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("result_timeout", int'(lat >= 40), 0);
  endtask

  task automatic run_one(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                         input int ex, input int ey, input int tol, input int es);
    int lat;
    start(x, y, z);
    wait_out(lat);
    chk("latency", lat, ITERS + 2);
    chk_tol("lit_x_out", int'($signed(bus.x_out)), ex, tol);
    chk_tol("lit_y_out", int'($signed(bus.y_out)), ey, tol);
    chk("lit_sat", int'(bus.sat), es);
    @(negedge clk);
  endtask

  initial begin
    res_t r;
    int   lat;
    logic signed [7:0] hx, hy;
    logic hs;

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.x_in = '0; bus.y_in = '0; bus.z_in = '0;

    r = model(64, 0, 0);
    chk("model_x0", r.x, 107);
    chk("model_y0", r.y, -1);
    r = model(64, 0, 32);
    chk("model_x45", r.x, 73);
    chk("model_y45", r.y, 76);

    // reset held three cycles
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_x_out",     int'($signed(bus.x_out)), 0);
    chk("rst_y_out",     int'($signed(bus.y_out)), 0);
    chk("rst_busy",      int'(busy), 0);

    run_one(8'h40, 8'h00, 8'h00,  105,    0, 2, 0);
    run_one(8'h40, 8'h00, 8'h40,    0,  105, 2, 0);
    run_one(8'h40, 8'h00, 8'h80, -105,    0, 2, 0);
    run_one(8'h7F, 8'h7F, 8'h00,  127,  127, 0, 1);

    // stall in DONE with in_valid pulsing
    bus.out_ready = 1'b0;
    start(8'h40, 8'h00, 8'h00);
    wait_out(lat);
    hx = bus.x_out; hy = bus.y_out; hs = bus.sat;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = ~bus.in_valid;
      bus.x_in = 8'($urandom); bus.z_in = 8'($urandom);
      @(negedge clk);
      chk("stall_x", int'(bus.x_out), int'(hx));
      chk("stall_y", int'(bus.y_out), int'(hy));
      chk("stall_sat", int'(bus.sat), int'(hs));
      chk("stall_in_ready", int'(bus.in_ready), 0);
      chk("stall_valid", int'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_idle", int'(bus.in_ready), 1);
    chk("release_valid", int'(bus.out_valid), 0);

    // reset during the third iteration cycle drops the in-flight result
    start(8'h40, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_valid", int'(bus.out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_x_out", int'($signed(bus.x_out)), 0);
    chk("midrst_sat", int'(bus.sat), 0);
    run_one(8'h40, 8'h00, 8'h20, 74, 74, 2, 0);

    // randomized traffic, occasional resets and backpressure
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.x_in = pick(); bus.y_in = pick(); bus.z_in = pick();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (15) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
